// File: rtl/matrix_result_drainer.sv
// Starts the matrix multiplier, waits for its done, then reads out all n*n results in row-major
// order on a strobe/ack stream. Optional running checksum when RESULT_CHECKSUM_EN is defined.
module matrix_result_drainer #(
  parameter int n     = 10,
  parameter int n_len = $clog2(n)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic             mul_start,
  input  logic             mul_done,
  output logic [n_len-1:0] rd_i,
  output logic [n_len-1:0] rd_j,
  input  logic [31:0]      rd_data,
  output logic [31:0]      out_data,
  output logic [n_len-1:0] out_i,
  output logic [n_len-1:0] out_j,
  output logic             out_last,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             busy,
  output logic             finished
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  // state     | meaning
  // IDLE      | waiting for go
  // START     | mul_start pulse
  // ARM       | one cycle that ignores a stale mul_done; read address reset
  // WAIT_DONE | waiting for the multiplier to finish
  // ADDR      | read address settles; element captured at the end of this cycle
  // HOLD      | element presented until out_ack
  // FINISH    | finished pulse, then back to IDLE
  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    WAIT_DONE,
    ADDR,
    HOLD,
    FINISH
  } state_t;

  localparam logic [n_len-1:0] last_idx = n_len'(n - 1);

  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mul_start <= 1'b0;
      rd_i      <= '0;
      rd_j      <= '0;
      out_data  <= '0;
      out_i     <= '0;
      out_j     <= '0;
      out_last  <= 1'b0;
      out_stb   <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state     <= START;
            mul_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        START: begin
          mul_start <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
          checksum  <= '0;
`endif
          state     <= ARM;
        end
        ARM: begin
          rd_i  <= '0;
          rd_j  <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (mul_done) state <= ADDR;
        end
        ADDR: begin
          out_data <= rd_data;
          out_i    <= rd_i;
          out_j    <= rd_j;
          out_last <= (rd_i == last_idx) && (rd_j == last_idx);
          out_stb  <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (out_ack) begin
            out_stb  <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            checksum <= checksum + out_data;
`endif
            if (out_last) begin
              finished <= 1'b1;
              state    <= FINISH;
            end else if (rd_j == last_idx) begin
              rd_j  <= '0;
              rd_i  <= rd_i + 1'b1;
              state <= ADDR;
            end else begin
              rd_j  <= rd_j + 1'b1;
              state <= ADDR;
            end
          end
        end
        FINISH: begin
          finished <= 1'b0;
          busy     <= 1'b0;
          rd_i     <= '0;
          rd_j     <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
